// File: rtl/top_serial_queue_pkg.sv
// Shared constants and types for the serial-to-parallel byte queue.
package top_serial_queue_pkg;
  localparam int WIDTH_C = 8;
  localparam int DEPTH_C = 8;
  localparam int PTR_W   = $clog2(DEPTH_C);

  typedef logic [WIDTH_C-1:0] word_t;
  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [PTR_W:0]     cnt_t;
endpackage

// File: rtl/top_serial_queue_fifo.sv
// Synchronous DEPTH_C x WIDTH_C FIFO with registered read data.
module top_serial_queue_fifo
  import top_serial_queue_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  word_t din,
  output word_t dout_reg,
  output logic  full,
  output logic  empty
);
  word_t mem_r [DEPTH_C];
  ptr_t  wr_ptr_r;
  ptr_t  rd_ptr_r;
  cnt_t  count_r;
  logic  push_ok_s;
  logic  pop_ok_s;

  // Status flags; a push into a full FIFO is legal when a pop frees the slot.
  always_comb begin
    full      = (count_r == cnt_t'(DEPTH_C));
    empty     = (count_r == cnt_t'(0));
    push_ok_s = push & (~full | pop);
    pop_ok_s  = pop & ~empty;
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= ptr_t'(0);
      rd_ptr_r <= ptr_t'(0);
      count_r  <= cnt_t'(0);
      dout_reg <= word_t'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ptr_t'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_t'(1);
        dout_reg <= mem_r[rd_ptr_r];
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + cnt_t'(1);
        2'b01:   count_r <= count_r - cnt_t'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/top_serial_queue.sv
// Serial MSB-first deserializer feeding a byte FIFO with a ready handshake.
// Optional MANUAL_ENQUEUE_EN: completed words enqueue only on an enqueue_in rise.
module top_serial_queue
  import top_serial_queue_pkg::*;
(
  input  logic               clock_1MHz,
  input  logic               rst,
  input  logic               data_in,
  input  logic               write_in,
  input  logic               enqueue_in,
  input  logic               dequeue_in,
  output logic               status_out,
  output logic [WIDTH_C-1:0] data_out
);
  localparam int BIT_W = $clog2(WIDTH_C);
  typedef logic [BIT_W-1:0] bit_cnt_t;
  localparam bit_cnt_t LAST_BIT = bit_cnt_t'(WIDTH_C - 1);

  logic     write_q_r;
  logic     dequeue_q_r;
  word_t    shift_r;
  bit_cnt_t bit_cnt_r;
  logic     pending_r;
  logic     status_r;
  logic     write_rise_s;
  logic     dequeue_rise_s;
  logic     accept_bit_s;
  logic     enq_ok_s;
  logic     push_s;
  logic     pop_s;
  logic     full_s;
  logic     empty_s;
  word_t    fifo_dout_s;

`ifdef MANUAL_ENQUEUE_EN
  logic enqueue_q_r;

  // Edge register for the manual enqueue strobe.
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      enqueue_q_r <= 1'b0;
    end else begin
      enqueue_q_r <= enqueue_in;
    end
  end

  assign enq_ok_s = enqueue_in & ~enqueue_q_r;
`else
  logic unused_enqueue_s;
  assign unused_enqueue_s = enqueue_in;
  assign enq_ok_s = 1'b1;
`endif

  // Strobe rise detection and queue control decisions.
  always_comb begin
    write_rise_s   = write_in & ~write_q_r;
    dequeue_rise_s = dequeue_in & ~dequeue_q_r;
    accept_bit_s   = write_rise_s & status_r;
    pop_s          = dequeue_rise_s & ~empty_s;
    push_s         = pending_r & enq_ok_s & (~full_s | pop_s);
  end

  // Edge registers for the write and dequeue strobes.
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      write_q_r   <= 1'b0;
      dequeue_q_r <= 1'b0;
    end else begin
      write_q_r   <= write_in;
      dequeue_q_r <= dequeue_in;
    end
  end

  // Deserializer: shift accepted bits in and flag a completed word.
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      shift_r   <= word_t'(0);
      bit_cnt_r <= bit_cnt_t'(0);
      pending_r <= 1'b0;
    end else begin
      if (accept_bit_s) begin
        shift_r   <= {shift_r[WIDTH_C-2:0], data_in};
        bit_cnt_r <= (bit_cnt_r == LAST_BIT) ? bit_cnt_t'(0) : bit_cnt_r + bit_cnt_t'(1);
      end
      if (accept_bit_s && (bit_cnt_r == LAST_BIT)) begin
        pending_r <= 1'b1;
      end else if (push_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Ready flag lags its condition by one cycle.
  always_ff @(posedge clock_1MHz) begin
    if (rst) begin
      status_r <= 1'b0;
    end else begin
      status_r <= ~pending_r & ~full_s;
    end
  end

  top_serial_queue_fifo u_fifo (
    .clk      (clock_1MHz),
    .rst      (rst),
    .push     (push_s),
    .pop      (pop_s),
    .din      (shift_r),
    .dout_reg (fifo_dout_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  assign status_out = status_r;
  assign data_out   = fifo_dout_s;
endmodule

// File: tb/tb_top_serial_queue.sv
// Directed plus randomized bench for top_serial_queue against a queue-based model.
`timescale 1ns/1ps
module tb_top_serial_queue;
  logic       clock_1MHz = 1'b0;
  logic       rst        = 1'b1;
  logic       data_in    = 1'b0;
  logic       write_in   = 1'b0;
  logic       enqueue_in = 1'b0;
  logic       dequeue_in = 1'b0;
  logic       status_out;
  logic [7:0] data_out;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  logic [7:0] model_q[$];
  logic [7:0] model_dout = 8'h00;

  top_serial_queue dut (
    .clock_1MHz (clock_1MHz),
    .rst        (rst),
    .data_in    (data_in),
    .write_in   (write_in),
    .enqueue_in (enqueue_in),
    .dequeue_in (dequeue_in),
    .status_out (status_out),
    .data_out   (data_out)
  );

  always #500 clock_1MHz = ~clock_1MHz;

  task automatic cycles(input int n);
    repeat (n) @(negedge clock_1MHz);
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
    return (model_q.size() < 8);
  endfunction

  task automatic send_bits(input logic [7:0] b, input int nbits);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < nbits; i++) begin
      data_in  = v[7-i];
      write_in = 1'b1;
      cycles(10);
      write_in = 1'b0;
      cycles(10);
    end
  endtask

  // A byte is taken only if the queue had room when sending started.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic accept;
    accept = model_ready();
    send_bits(b, 8);
    if (accept) model_q.push_back(b);
    cycles(gap);
  endtask

  task automatic dequeue(input int hold);
    dequeue_in = 1'b1;
    cycles(hold);
    dequeue_in = 1'b0;
    cycles(5);
    if (model_q.size() > 0) model_dout = model_q.pop_front();
  endtask

  task automatic check_state(input string tag);
    check8({tag, "_data"}, data_out, model_dout);
    check1({tag, "_status"}, status_out, model_ready());
  endtask

  initial begin
    // reset for 3 cycles
    cycles(1);
    check1("status_in_reset", status_out, 1'b0);
    cycles(2);
    rst = 1'b0;
    cycles(1);
    check1("status_after_release", status_out, 1'b1);
    check8("data_after_reset", data_out, 8'h00);

    // single byte, long dequeue pulse counts once
    send_byte(8'h80, 20);
    check1("status_one_byte", status_out, 1'b1);
    dequeue(200);
    check_state("deq_long_pulse");
    dequeue(10);
    check_state("deq_after_single");

    // fill to full, extra bytes ignored
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h80 + 8'(i), 300);
      check1($sformatf("fill_status_%0d", i), status_out, model_ready());
    end
    check1("status_full", status_out, 1'b0);
    send_byte(8'($urandom), 300);
    send_byte(8'($urandom), 300);
    check1("status_full_after_extra", status_out, 1'b0);

    // pop 4, refill 4
    for (int i = 0; i < 4; i++) begin
      dequeue(20);
      check_state($sformatf("pop4_%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h88 + 8'(i), 40);
      check1($sformatf("refill_status_%0d", i), status_out, model_ready());
    end

    // drain, then dequeue on empty holds data_out
    while (model_q.size() > 0) begin
      dequeue(15);
      check_state("drain");
    end
    dequeue(15);
    check_state("deq_empty_hold");

    // pointer wrap with random data
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 30);
    check1("wrap_full_status", status_out, 1'b0);
    for (int i = 0; i < 8; i++) begin
      dequeue(12);
      check_state("wrap_pop");
    end
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 30);
    while (model_q.size() > 0) begin
      dequeue(12);
      check_state("wrap_drain");
    end

    // random mix of sends and dequeues
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        send_byte(8'($urandom), 30);
        check_state("rand_send");
      end else begin
        dequeue(int'($urandom_range(1, 50)));
        check_state("rand_deq");
      end
    end

    // reset mid-word discards partial word and queue
    send_byte(8'hC3, 30);
    send_bits(8'hFF, 3);
    rst = 1'b1;
    cycles(2);
    model_q.delete();
    model_dout = 8'h00;
    check1("status_mid_reset", status_out, 1'b0);
    check8("data_mid_reset", data_out, 8'h00);
    rst = 1'b0;
    cycles(1);
    check1("status_after_mid_reset", status_out, 1'b1);
    send_byte(8'h5A, 20);
    dequeue(10);
    check_state("deq_5a");
    dequeue(10);
    check_state("deq_after_5a");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
